// File: rtl/ias_pkg.sv
// Shared types for the IAS datapath registers.
// Word width and the per-edge action selected by the control inputs.
package ias_pkg;

    localparam int IAS_WORD_W = 8;

    typedef logic [IAS_WORD_W-1:0] ias_word_t;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_INC,
        OP_LOAD,
        OP_CLEAR
    } ias_op_t;

    // clear beats load beats inc; rst is handled at the flop itself
    function automatic ias_op_t ias_sel_op(
        input logic clear,
        input logic load,
        input logic inc
    );
        ias_op_t op;
        if (clear) begin
            op = OP_CLEAR;
        end else if (load) begin
            op = OP_LOAD;
        end else if (inc) begin
            op = OP_INC;
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/ias_register.sv
// General-purpose IAS register: load, clear, increment with wrap pulse.
// Outputs come straight from flops; one-cycle latency on every control.
module ias_register
    import ias_pkg::*;
#(
    parameter int              WIDTH       = IAS_WORD_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             inc,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             wrap
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             wrap_q;
    logic             wrap_d;
    ias_op_t          op;

    always_comb begin
        op     = ias_sel_op(clear, load, inc);
        data_d = data_q;
        wrap_d = 1'b0;
        unique case (op)
            OP_CLEAR: data_d = '0;
            OP_LOAD:  data_d = data_in;
            OP_INC: begin
                data_d = data_q + WIDTH'(1);
                wrap_d = &data_q;
            end
            OP_HOLD:  data_d = data_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RESET_VALUE;
            wrap_q <= 1'b0;
        end else begin
            data_q <= data_d;
            wrap_q <= wrap_d;
        end
    end

    assign data_out = data_q;
    assign wrap     = wrap_q;

    // a wrap pulse can only follow an all-ones increment
    always @(posedge clk) begin
        if (wrap_q) begin
            assert (data_q == '0);
        end
    end

endmodule

// File: tb/tb_ias_register.sv
// Self-checking bench for ias_register: directed scenarios plus
// randomized control traffic against a behavioural model.
module tb_ias_register;

    logic       clk;
    logic       rst;
    logic       load;
    logic       clear;
    logic       inc;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       wrap;

    int total;
    int bad;

    int m_val;
    bit m_wrap;

    ias_register #(
        .WIDTH      (8),
        .RESET_VALUE(8'h00)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .clear   (clear),
        .inc     (inc),
        .data_in (data_in),
        .data_out(data_out),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drive one edge's worth of controls and advance the model
    task automatic step(
        input logic       r,
        input logic       c,
        input logic       l,
        input logic       i,
        input logic [7:0] d
    );
        rst     = r;
        clear   = c;
        load    = l;
        inc     = i;
        data_in = d;
        @(posedge clk);
        if (r) begin
            m_val  = 0;
            m_wrap = 0;
        end else if (c) begin
            m_val  = 0;
            m_wrap = 0;
        end else if (l) begin
            m_val  = int'(d);
            m_wrap = 0;
        end else if (i) begin
            m_wrap = (m_val == 255);
            m_val  = (m_val + 1) % 256;
        end else begin
            m_wrap = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 8'h00);
        total++;
        if (data_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_data: got=%h want=00", data_out);
        end
        total++;
        if (wrap !== 1'b0) begin
            bad++;
            $display("FAIL reset_wrap: got=%b want=0", wrap);
        end
    endtask

    task automatic test_load_inc_clear();
        step(0, 0, 1, 0, 8'h55);
        total++;
        if (data_out !== 8'h55) begin
            bad++;
            $display("FAIL load55: got=%h want=55", data_out);
        end
        step(0, 0, 0, 1, 8'h00);
        total++;
        if (data_out !== 8'h56 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL inc56: got=%h/%b want=56/0", data_out, wrap);
        end
        step(0, 1, 0, 0, 8'h00);
        total++;
        if (data_out !== 8'h00 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL clear: got=%h/%b want=00/0", data_out, wrap);
        end
    endtask

    task automatic test_wrap();
        step(0, 0, 1, 0, 8'hFE);
        step(0, 0, 0, 1, 8'h00);
        total++;
        if (data_out !== 8'hFF || wrap !== 1'b0) begin
            bad++;
            $display("FAIL inc_ff: got=%h/%b want=ff/0", data_out, wrap);
        end
        step(0, 0, 0, 1, 8'h00);
        total++;
        if (data_out !== 8'h00 || wrap !== 1'b1) begin
            bad++;
            $display("FAIL wrap_pulse: got=%h/%b want=00/1", data_out, wrap);
        end
        step(0, 0, 0, 0, 8'h00);
        total++;
        if (data_out !== 8'h00 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL wrap_drop: got=%h/%b want=00/0", data_out, wrap);
        end
        // load of all-ones must not itself pulse wrap
        step(0, 0, 1, 0, 8'hFF);
        total++;
        if (data_out !== 8'hFF || wrap !== 1'b0) begin
            bad++;
            $display("FAIL load_ff: got=%h/%b want=ff/0", data_out, wrap);
        end
    endtask

    task automatic test_priority();
        step(0, 1, 1, 1, 8'hA5);
        total++;
        if (data_out !== 8'h00) begin
            bad++;
            $display("FAIL clr_ld_inc: got=%h want=00", data_out);
        end
        step(0, 0, 1, 1, 8'hA5);
        total++;
        if (data_out !== 8'hA5 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL ld_inc: got=%h/%b want=a5/0", data_out, wrap);
        end
        step(0, 0, 1, 1, 8'hFF);
        step(0, 1, 0, 1, 8'h00);
        total++;
        if (data_out !== 8'h00 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL clr_inc_ff: got=%h/%b want=00/0", data_out, wrap);
        end
    endtask

    task automatic test_rst_override();
        step(0, 0, 1, 0, 8'h3C);
        step(1, 0, 1, 0, 8'h77);
        total++;
        if (data_out !== 8'h00 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL rst_override: got=%h/%b want=00/0", data_out, wrap);
        end
        step(0, 0, 1, 0, 8'h77);
        total++;
        if (data_out !== 8'h77) begin
            bad++;
            $display("FAIL rst_resume: got=%h want=77", data_out);
        end
    endtask

    task automatic test_hold();
        step(0, 0, 1, 0, 8'h12);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0, 8'($urandom));
            total++;
            if (data_out !== 8'h12 || wrap !== 1'b0) begin
                bad++;
                $display("FAIL hold%0d: got=%h/%b want=12/0", k, data_out, wrap);
            end
        end
    endtask

    task automatic test_random();
        logic r, c, l, i;
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 9) == 0);
            l = ($urandom_range(0, 4) == 0);
            i = ($urandom_range(0, 1) == 0);
            // bias toward the top of the range so wraps happen often
            step(r, c, l, i, ($urandom_range(0, 1) == 0) ? 8'hFF - 8'($urandom_range(0, 3)) : 8'($urandom));
            total++;
            if (data_out !== m_val[7:0] || wrap !== m_wrap) begin
                bad++;
                $display("FAIL rand%0d: got=%h/%b want=%h/%b", k, data_out, wrap, m_val[7:0], m_wrap);
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        m_val   = 0;
        m_wrap  = 0;
        rst     = 1'b1;
        load    = 1'b0;
        clear   = 1'b0;
        inc     = 1'b0;
        data_in = 8'h00;
        @(negedge clk);
        test_reset();
        test_load_inc_clear();
        test_wrap();
        test_priority();
        test_rst_override();
        test_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
